// File: rtl/sample_packer_pkg.sv
// Shared types and configuration helpers for the sample packer.
// No logic; pure elaboration-time definitions.
package sample_packer_pkg;

    localparam int SAMPLE_W_DEF         = 16;
    localparam int CHUNK_W_DEF          = 128;
    localparam int INSTRUMENT_COUNT_DEF = 8;
    localparam int ADDR_W_DEF           = 24;

    typedef enum logic {
        FILL = 1'b0,
        DONE = 1'b1
    } state_t;

    function automatic int lanes(input int sample_w, input int chunk_w);
        return chunk_w / sample_w;
    endfunction

    function automatic bit cfg_ok(input int sample_w, input int chunk_w);
        if (sample_w <= 0)
            return 1'b0;
        return ((chunk_w % sample_w) == 0) && (lanes(sample_w, chunk_w) >= 2);
    endfunction

endpackage

// File: rtl/sample_packer_offsets.sv
// Purpose: instrument/chunk counters, DRAM offset table, load-complete FSM, sticky overflow.
// Latency: table entry and valid flag update on the same edge as the chunk load.
// Backpressure: none; reacts only to strobes qualified by the packer datapath.
module sample_packer_offsets
    import sample_packer_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = INSTRUMENT_COUNT_DEF,
    parameter int ADDR_W           = ADDR_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  chunk_load,
    input  logic                                  chunk_last,
    input  logic                                  sample_drop,
    output logic                                  done,
    output logic [INSTRUMENT_COUNT:0][ADDR_W-1:0] addr_offsets,
    output logic                                  addr_offsets_valid,
    output logic                                  overflow
);

    localparam int                INST_W    = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;
    localparam logic [INST_W-1:0] LAST_INST = INST_W'(INSTRUMENT_COUNT - 1);
    localparam logic [ADDR_W-1:0] CNT_MAX   = '1;

    state_t                                  state_q, state_d;
    logic [INST_W-1:0]                       inst_q;
    logic [ADDR_W-1:0]                       chunk_cnt_q;
    logic [ADDR_W-1:0]                       chunk_cnt_inc;
    logic                                    cnt_sat;
    logic [INSTRUMENT_COUNT-1:0][ADDR_W-1:0] off_tbl_q;

    assign cnt_sat       = (chunk_cnt_q == CNT_MAX);
    assign chunk_cnt_inc = cnt_sat ? CNT_MAX : chunk_cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        if (state_q == FILL && chunk_load && chunk_last && inst_q == LAST_INST)
            state_d = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= FILL;
        else
            state_q <= state_d;
    end

    // off_tbl_q[k] holds offset of instrument k+1; entry 0 is the constant base
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q      <= '0;
            chunk_cnt_q <= '0;
            off_tbl_q   <= '0;
            overflow    <= 1'b0;
        end else begin
            if (chunk_load) begin
                chunk_cnt_q <= chunk_cnt_inc;
                if (cnt_sat)
                    overflow <= 1'b1;
                if (chunk_last && state_q == FILL) begin
                    off_tbl_q[inst_q] <= chunk_cnt_inc;
                    inst_q            <= inst_q + 1'b1;
                end
            end
            if (sample_drop)
                overflow <= 1'b1;
        end
    end

    assign done               = (state_q == DONE);
    assign addr_offsets_valid = done;
    assign addr_offsets       = {off_tbl_q, {ADDR_W{1'b0}}};

endmodule

// File: rtl/sample_packer.sv
// Purpose: pack SAMPLE_W samples into zero-padded CHUNK_W words; SAMPLE_PACKER_MSB_FIRST_EN puts the first sample in the top lane.
// Latency: chunk appears on m_tvalid one cycle after its completing sample is accepted.
// Backpressure: s_tready = !m_tvalid || m_tready while filling; always ready (dropping) once all instruments are loaded.
module sample_packer
    import sample_packer_pkg::*;
#(
    parameter int SAMPLE_W         = SAMPLE_W_DEF,
    parameter int CHUNK_W          = CHUNK_W_DEF,
    parameter int INSTRUMENT_COUNT = INSTRUMENT_COUNT_DEF,
    parameter int ADDR_W           = ADDR_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  s_tvalid,
    output logic                                  s_tready,
    input  logic [SAMPLE_W-1:0]                   s_tdata,
    input  logic                                  s_tlast,
    output logic                                  m_tvalid,
    input  logic                                  m_tready,
    output logic [CHUNK_W-1:0]                    m_tdata,
    output logic                                  m_tlast,
    output logic [INSTRUMENT_COUNT:0][ADDR_W-1:0] addr_offsets,
    output logic                                  addr_offsets_valid,
    output logic                                  overflow
);

    localparam int                LANES     = lanes(SAMPLE_W, CHUNK_W);
    localparam int                LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    if (!cfg_ok(SAMPLE_W, CHUNK_W)) begin : g_cfg_check
        $error("sample_packer: CHUNK_W must be a multiple of SAMPLE_W with at least two lanes");
    end

    logic [LANE_W-1:0]  lane_q;
    logic [CHUNK_W-1:0] acc_q;
    logic [CHUNK_W-1:0] acc_next;
    logic               accept;
    logic               chunk_load;
    logic               sample_drop;
    logic               done;

    assign s_tready    = done || !m_tvalid || m_tready;
    assign accept      = s_tvalid && s_tready;
    assign chunk_load  = accept && !done && (s_tlast || lane_q == LAST_LANE);
    assign sample_drop = accept && done;

    // Unfilled lanes stay zero because the accumulator clears on every load
    always_comb begin
        acc_next = acc_q;
`ifdef SAMPLE_PACKER_MSB_FIRST_EN
        acc_next[CHUNK_W - 1 - int'(lane_q) * SAMPLE_W -: SAMPLE_W] = s_tdata;
`else
        acc_next[int'(lane_q) * SAMPLE_W +: SAMPLE_W] = s_tdata;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            acc_q  <= '0;
        end else if (accept && !done) begin
            if (chunk_load) begin
                lane_q <= '0;
                acc_q  <= '0;
            end else begin
                lane_q <= lane_q + 1'b1;
                acc_q  <= acc_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
        end else if (chunk_load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= acc_next;
            m_tlast  <= s_tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    sample_packer_offsets #(
        .INSTRUMENT_COUNT (INSTRUMENT_COUNT),
        .ADDR_W           (ADDR_W)
    ) u_offsets (
        .clk                (clk),
        .rst_n              (rst_n),
        .chunk_load         (chunk_load),
        .chunk_last         (s_tlast),
        .sample_drop        (sample_drop),
        .done               (done),
        .addr_offsets       (addr_offsets),
        .addr_offsets_valid (addr_offsets_valid),
        .overflow           (overflow)
    );

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer with two instruments per load.
module tb_sample_packer;

    localparam int SW    = 16;
    localparam int CW    = 128;
    localparam int IC    = 2;
    localparam int AW    = 24;
    localparam int LANES = CW / SW;

    logic                    clk   = 1'b0;
    logic                    rst_n = 1'b1;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [SW-1:0]           s_tdata;
    logic                    s_tlast;
    logic                    m_tvalid;
    logic                    m_tready;
    logic [CW-1:0]           m_tdata;
    logic                    m_tlast;
    logic [IC:0][AW-1:0]     addr_offsets;
    logic                    addr_offsets_valid;
    logic                    overflow;

    sample_packer #(
        .SAMPLE_W         (SW),
        .CHUNK_W          (CW),
        .INSTRUMENT_COUNT (IC),
        .ADDR_W           (AW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_tvalid           (s_tvalid),
        .s_tready           (s_tready),
        .s_tdata            (s_tdata),
        .s_tlast            (s_tlast),
        .m_tvalid           (m_tvalid),
        .m_tready           (m_tready),
        .m_tdata            (m_tdata),
        .m_tlast            (m_tlast),
        .addr_offsets       (addr_offsets),
        .addr_offsets_valid (addr_offsets_valid),
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [CW-1:0] dat;
        logic          last;
    } exp_chunk_t;

    exp_chunk_t          exp_q[$];
    int                  n_tests = 0;
    int                  n_fail  = 0;
    int                  n_chunks_seen = 0;
    logic [CW-1:0]       last_chunk = '0;
    logic [CW-1:0]       mdl_acc;
    int                  mdl_lane;
    int                  mdl_chunks;
    int                  mdl_inst;
    logic [IC:0][AW-1:0] mdl_off;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] place(input logic [CW-1:0] acc, input int lane, input logic [SW-1:0] d);
        logic [CW-1:0] r;
        r = acc;
`ifdef SAMPLE_PACKER_MSB_FIRST_EN
        r[CW - 1 - lane * SW -: SW] = d;
`else
        r[lane * SW +: SW] = d;
`endif
        return r;
    endfunction

    task automatic mdl_clear();
        mdl_acc    = '0;
        mdl_lane   = 0;
        mdl_chunks = 0;
        mdl_inst   = 0;
        mdl_off    = '0;
        exp_q.delete();
    endtask

    task automatic mdl_push(input logic [SW-1:0] d, input logic last);
        exp_chunk_t e;
        if (mdl_inst >= IC)
            return;
        mdl_acc = place(mdl_acc, mdl_lane, d);
        if (last || mdl_lane == LANES - 1) begin
            e.dat  = mdl_acc;
            e.last = last;
            exp_q.push_back(e);
            mdl_acc  = '0;
            mdl_lane = 0;
            mdl_chunks++;
            if (last) begin
                mdl_off[mdl_inst + 1] = AW'(mdl_chunks);
                mdl_inst++;
            end
        end else begin
            mdl_lane++;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("spurious_chunk", CW'(m_tvalid), CW'(0));
            end else begin
                exp_chunk_t e;
                e = exp_q.pop_front();
                check("chunk_dat", m_tdata, e.dat);
                check("chunk_last", CW'(m_tlast), CW'(e.last));
            end
            last_chunk = m_tdata;
            n_chunks_seen++;
        end
    end

    task automatic do_reset();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("rst_m_tvalid", CW'(m_tvalid), CW'(0));
        check("rst_m_tdata", m_tdata, '0);
        check("rst_m_tlast", CW'(m_tlast), CW'(0));
        check("rst_offsets", CW'(addr_offsets), '0);
        check("rst_valid", CW'(addr_offsets_valid), CW'(0));
        check("rst_overflow", CW'(overflow), CW'(0));
        check("rst_s_tready", CW'(s_tready), CW'(1));
        mdl_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [SW-1:0] d, input logic last);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            check("s_tready_timeout", CW'(s_tready), CW'(1));
        else
            mdl_push(d, last);
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_left", CW'(exp_q.size()), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0]       k8, k3, hold_dat, k_clean;
        logic [IC:0][AW-1:0] saved_off;
        logic [IC:0][AW-1:0] exp_off;
        int                  t0, seen0;

`ifdef SAMPLE_PACKER_MSB_FIRST_EN
        k8 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        k3 = 128'h0001_0002_0003_0000_0000_0000_0000_0000;
`else
        k8 = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
        k3 = 128'h0000_0000_0000_0000_0000_0003_0002_0001;
`endif
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        #2;
        do_reset();

        // instrument 0: one full chunk; instrument 1: padded 3-sample chunk
        for (int i = 1; i <= 8; i++)
            send(SW'(i), i == 8);
        drain();
        check("full_chunk_const", last_chunk, k8);
        check("offset1_after_inst0", CW'(addr_offsets[1]), CW'(1));
        check("valid_before_final", CW'(addr_offsets_valid), CW'(0));
        for (int i = 1; i <= 3; i++)
            send(SW'(i), i == 3);
        drain();
        check("pad_chunk_const", last_chunk, k3);
        check("offset2_after_inst1", CW'(addr_offsets[2]), CW'(2));
        check("offsets_vs_model", CW'(addr_offsets), CW'(mdl_off));
        check("valid_after_final", CW'(addr_offsets_valid), CW'(1));
        check("overflow_before_drop", CW'(overflow), CW'(0));

        // DONE: samples are swallowed without output
        saved_off = addr_offsets;
        seen0     = n_chunks_seen;
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = SW'(16'hAA00 + i);
            s_tlast  = (i == 3);
            @(negedge clk);
            check("done_s_tready", CW'(s_tready), CW'(1));
            @(posedge clk);
            #1;
            check("done_no_m_tvalid", CW'(m_tvalid), CW'(0));
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("done_overflow", CW'(overflow), CW'(1));
        check("done_offsets_held", CW'(addr_offsets), CW'(saved_off));
        check("done_chunk_count", CW'(n_chunks_seen - seen0), '0);

        // 20 + 8 samples with a 5-cycle stall on the first chunk
        do_reset();
        seen0    = n_chunks_seen;
        m_tready = 1'b0;
        for (int i = 1; i <= 8; i++)
            send(SW'(16'h0100 + i), 1'b0);
        hold_dat = exp_q[0].dat;
        s_tvalid = 1'b1;
        s_tdata  = SW'(16'h0109);
        s_tlast  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_s_tready", CW'(s_tready), CW'(0));
            check("bp_m_tvalid", CW'(m_tvalid), CW'(1));
            check("bp_m_tdata", m_tdata, hold_dat);
            @(posedge clk);
            #1;
        end
        m_tready = 1'b1;
        t0       = cyc;
        for (int i = 9; i <= 20; i++)
            send(SW'(16'h0100 + i), i == 20);
        check("throughput_cycles", CW'(cyc - t0), CW'(12));
        for (int i = 1; i <= 8; i++) begin
            if (i == 8)
                check("valid_before_last_load", CW'(addr_offsets_valid), CW'(0));
            send(SW'(16'h0200 + i), i == 8);
        end
        exp_off = {AW'(4), AW'(3), AW'(0)};
        check("valid_with_last_load", CW'(addr_offsets_valid), CW'(1));
        check("offsets_const", CW'(addr_offsets), CW'(exp_off));
        drain();
        check("chunk_count_28", CW'(n_chunks_seen - seen0), CW'(4));

        // mid-chunk reset must leave no residue
        do_reset();
        for (int i = 1; i <= 5; i++)
            send(SW'(16'h0300 + i), 1'b0);
        do_reset();
        k_clean = '0;
        for (int i = 1; i <= 8; i++) begin
            k_clean = place(k_clean, i - 1, SW'(16'h0400 + i));
            send(SW'(16'h0400 + i), 1'b0);
        end
        drain();
        check("clean_chunk_after_reset", last_chunk, k_clean);
        check("clean_chunk_m_tlast", CW'(m_tlast), CW'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
